// File: rtl/mem_tdp_pipe_if.sv
// One memory port's request/response bundle for mem_tdp_pipe.
// The master drives the request, and the slave (the RAM) returns read data with a valid strobe.
interface mem_tdp_pipe_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) ();
    localparam int NB = DATA_WIDTH / 8;

    logic                  en;
    logic                  we;
    logic [NB-1:0]         wstrb;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rvalid;

    modport master (output en, we, wstrb, addr, din, input dout, rvalid);
    modport slave  (input en, we, wstrb, addr, din, output dout, rvalid);
endinterface

// File: rtl/mem_tdp_pipe.sv
// True dual-port byte-strobed RAM with per-port read-during-write mode,
// 1- or 2-cycle read latency, a write-collision flag and a clear engine that fills the array.
module mem_tdp_pipe #(
    parameter int                      ADDR_WIDTH     = 10,
    parameter int                      DATA_WIDTH     = 32,
    parameter int                      READ_LATENCY   = 1,
    parameter int                      RDW_MODE_A     = 0,
    parameter int                      RDW_MODE_B     = 0,
    parameter int                      CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0]   INIT_VALUE     = {DATA_WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear_req,
    output logic             o_init_busy,
    mem_tdp_pipe_if.slave    port_a,
    mem_tdp_pipe_if.slave    port_b,
    output logic             o_collision
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_acc_a, w_acc_b, w_wr_a, w_wr_b;
    logic [DATA_WIDTH-1:0] w_old_a, w_old_b, w_own_a, w_own_b, w_rd_a, w_rd_b;
    logic                  r_rv1_a, r_rv1_b, r_coll;
    logic [DATA_WIDTH-1:0] r_rd1_a, r_rd1_b;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // Request acceptance and per-port read data (old word or own merged word).
    always_comb begin
        w_acc_a = port_a.en & ~r_busy;
        w_acc_b = port_b.en & ~r_busy;
        w_wr_a  = w_acc_a & port_a.we;
        w_wr_b  = w_acc_b & port_b.we;
        w_old_a = r_mem[port_a.addr];
        w_old_b = r_mem[port_b.addr];
        w_own_a = merge_bytes(w_old_a, port_a.din, w_wr_a ? port_a.wstrb : {NB{1'b0}});
        w_own_b = merge_bytes(w_old_b, port_b.din, w_wr_b ? port_b.wstrb : {NB{1'b0}});
        w_rd_a  = (RDW_MODE_A != 0) ? w_own_a : w_old_a;
        w_rd_b  = (RDW_MODE_B != 0) ? w_own_b : w_old_b;
    end

    // Array update: clear sweep, else byte writes with port B applied last so it wins overlaps.
    always_ff @(posedge clk) begin
        if (r_busy) begin
            r_mem[r_clr_addr] <= INIT_VALUE;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (w_wr_a && port_a.wstrb[i]) r_mem[port_a.addr][8*i +: 8] <= port_a.din[8*i +: 8];
            end
            for (int i = 0; i < NB; i++) begin
                if (w_wr_b && port_b.wstrb[i]) r_mem[port_b.addr][8*i +: 8] <= port_b.din[8*i +: 8];
            end
        end
    end

    // Clear engine FSM; clear_req is only honoured from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_busy     <= (CLEAR_ON_RESET != 0);
            r_clr_addr <= {ADDR_WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_clear_req) begin
                        r_state    <= S_CLEAR;
                        r_busy     <= 1'b1;
                        r_clr_addr <= {ADDR_WIDTH{1'b0}};
                    end
                end
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == {ADDR_WIDTH{1'b1}}) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // First read stage and collision flag; read data holds when no access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rv1_a <= 1'b0;
            r_rv1_b <= 1'b0;
            r_rd1_a <= {DATA_WIDTH{1'b0}};
            r_rd1_b <= {DATA_WIDTH{1'b0}};
            r_coll  <= 1'b0;
        end else begin
            r_rv1_a <= w_acc_a;
            r_rv1_b <= w_acc_b;
            if (w_acc_a) r_rd1_a <= w_rd_a;
            if (w_acc_b) r_rd1_b <= w_rd_b;
            r_coll  <= w_wr_a & w_wr_b & (port_a.addr == port_b.addr) &
                       (|(port_a.wstrb & port_b.wstrb));
        end
    end

    assign o_init_busy = r_busy;
    assign o_collision = r_coll;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_rv2_a, r_rv2_b;
        logic [DATA_WIDTH-1:0] r_rd2_a, r_rd2_b;

        // Plain output register stage.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rv2_a <= 1'b0;
                r_rv2_b <= 1'b0;
                r_rd2_a <= {DATA_WIDTH{1'b0}};
                r_rd2_b <= {DATA_WIDTH{1'b0}};
            end else begin
                r_rv2_a <= r_rv1_a;
                r_rv2_b <= r_rv1_b;
                if (r_rv1_a) r_rd2_a <= r_rd1_a;
                if (r_rv1_b) r_rd2_b <= r_rd1_b;
            end
        end

        assign port_a.dout   = r_rd2_a;
        assign port_a.rvalid = r_rv2_a;
        assign port_b.dout   = r_rd2_b;
        assign port_b.rvalid = r_rv2_b;
    end else begin : g_lat1
        assign port_a.dout   = r_rd1_a;
        assign port_a.rvalid = r_rv1_a;
        assign port_b.dout   = r_rd1_b;
        assign port_b.rvalid = r_rv1_b;
    end
endmodule

// File: tb/tb_mem_tdp_pipe.sv
// Bench for mem_tdp_pipe: three instances (read-first/L1, write-first/L1, read-first/L2)
// share one directed stimulus and are checked every cycle against a behavioural model.
module tb_mem_tdp_pipe;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int NI = 3;
    localparam logic [31:0] INIT = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;
    logic clear_req, en_a, we_a, en_b, we_b;
    logic [3:0] sa, sb, aa, ab;
    logic [31:0] da, db;

    logic [31:0] dout_a_w [NI];
    logic [31:0] dout_b_w [NI];
    logic rv_a_w [NI];
    logic rv_b_w [NI];
    logic busy_w [NI];
    logic coll_w [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_tdp_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_pa ();
        mem_tdp_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_pb ();
        assign u_pa.en = en_a;  assign u_pa.we = we_a;  assign u_pa.wstrb = sa;
        assign u_pa.addr = aa;  assign u_pa.din = da;
        assign u_pb.en = en_b;  assign u_pb.we = we_b;  assign u_pb.wstrb = sb;
        assign u_pb.addr = ab;  assign u_pb.din = db;
        assign dout_a_w[g] = u_pa.dout;  assign rv_a_w[g] = u_pa.rvalid;
        assign dout_b_w[g] = u_pb.dout;  assign rv_b_w[g] = u_pb.rvalid;
        mem_tdp_pipe #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
            .READ_LATENCY((g == 2) ? 2 : 1),
            .RDW_MODE_A((g == 1) ? 1 : 0), .RDW_MODE_B((g == 1) ? 1 : 0),
            .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)
        ) u_dut (
            .clk(clk), .rst(rst), .i_clear_req(clear_req), .o_init_busy(busy_w[g]),
            .port_a(u_pa), .port_b(u_pb), .o_collision(coll_w[g])
        );
    end

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {int due; logic [31:0] data;} rd_t;
    logic [31:0] mdl [DEPTH];
    bit mbusy;
    int mcnt;
    int ecnt = 0;
    rd_t q [2*NI][$];
    logic [31:0] exp_do [2*NI];
    bit exp_rv [2*NI];
    bit exp_coll;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic model_step();
        logic [31:0] old_a, old_b, own_a, own_b;
        bit acc_a, acc_b;
        rd_t e;
        if (rst) begin
            mbusy = 1'b1; mcnt = 0; exp_coll = 1'b0;
            for (int k = 0; k < 2*NI; k++) begin
                q[k].delete(); exp_do[k] = 32'h0; exp_rv[k] = 1'b0;
            end
        end else begin
            ecnt++;
            acc_a = en_a && !mbusy;
            acc_b = en_b && !mbusy;
            exp_coll = acc_a && acc_b && we_a && we_b && (aa == ab) && ((sa & sb) != 4'h0);
            if (mbusy) begin
                mdl[mcnt] = INIT;
                mcnt++;
                if (mcnt == DEPTH) mbusy = 1'b0;
            end else begin
                old_a = mdl[aa];
                old_b = mdl[ab];
                own_a = merge(old_a, da, we_a ? sa : 4'h0);
                own_b = merge(old_b, db, we_b ? sb : 4'h0);
                if (acc_a && we_a) mdl[aa] = own_a;
                if (acc_b && we_b) mdl[ab] = merge(mdl[ab], db, sb);
                for (int g = 0; g < NI; g++) begin
                    e.due = ecnt + ((g == 2) ? 1 : 0);
                    if (acc_a) begin e.data = (g == 1) ? own_a : old_a; q[2*g].push_back(e); end
                    if (acc_b) begin e.data = (g == 1) ? own_b : old_b; q[2*g+1].push_back(e); end
                end
                if (clear_req) begin mbusy = 1'b1; mcnt = 0; end
            end
            for (int k = 0; k < 2*NI; k++) begin
                exp_rv[k] = 1'b0;
                if (q[k].size() > 0 && q[k][0].due == ecnt) begin
                    exp_rv[k] = 1'b1;
                    exp_do[k] = q[k][0].data;
                    void'(q[k].pop_front());
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Every-cycle comparison of all instances against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int g = 0; g < NI; g++) begin
                chk($sformatf("busy%0d", g), 32'(busy_w[g]), 32'(mbusy));
                chk($sformatf("coll%0d", g), 32'(coll_w[g]), 32'(exp_coll));
                chk($sformatf("rv_a%0d", g), 32'(rv_a_w[g]), 32'(exp_rv[2*g]));
                chk($sformatf("rv_b%0d", g), 32'(rv_b_w[g]), 32'(exp_rv[2*g+1]));
                chk($sformatf("dout_a%0d", g), dout_a_w[g], exp_do[2*g]);
                chk($sformatf("dout_b%0d", g), dout_b_w[g], exp_do[2*g+1]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0; clear_req = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    task automatic acc(input logic ea, input logic wa, input logic [3:0] s_a, input logic [3:0] a_a,
                       input logic [31:0] d_a, input logic eb, input logic wb, input logic [3:0] s_b,
                       input logic [3:0] a_b, input logic [31:0] d_b);
        en_a = ea; we_a = wa; sa = s_a; aa = a_a; da = d_a;
        en_b = eb; we_b = wb; sb = s_b; ab = a_b; db = d_b;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 4) begin en_a = 1'b1; we_a = 1'b1; sa = 4'hF; aa = 4'd2; da = 32'hCAFEF00D; end
            if (i == 5) idle();
            if (i == 8) clear_req = 1'b1;
            if (i == 9) idle();
            if (busy_w[0]) n++;
            else break;
        end
        chk(nm, n, 32'd16);
        settle();
    endtask

    initial begin
        logic        rvlog [5];
        logic [31:0] dlog  [5];
        rst = 1'b1; idle(); sa = 4'h0; sb = 4'h0; aa = 4'h0; ab = 4'h0; da = 32'h0; db = 32'h0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        chk("reset_dout", dout_a_w[0], 32'h0);
        chk("reset_busy", 32'(busy_w[0]), 32'd1);
        settle();
        rst = 1'b0;
        count_busy("busy_len_reset");

        // Read back the cleared array on both ports.
        for (int i = 0; i < DEPTH; i++)
            acc(1'b1, 1'b0, 4'h0, i[3:0], 32'h0, 1'b1, 1'b0, 4'h0, 4'(15 - i), 32'h0);
        @(negedge clk);
        chk("clr_rd15", dout_a_w[0], INIT);
        chk("clr_rv15", 32'(rv_a_w[0]), 32'd1);
        settle();

        // Byte-strobed write and cross-port read of the same address.
        acc(1'b1, 1'b1, 4'hF, 4'd3, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        acc(1'b1, 1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        @(negedge clk);
        chk("xport_old", dout_b_w[0], 32'h00000000);
        chk("rf_a3", dout_a_w[0], 32'h00000000);
        chk("wf_a3", dout_a_w[1], 32'h00220044);
        settle();
        acc(1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        @(negedge clk);
        chk("strb_rd3", dout_a_w[0], 32'h00220044);
        settle();

        // Read-during-write modes.
        acc(1'b1, 1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        acc(1'b1, 1'b1, 4'b0011, 4'd5, 32'h01020304, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        @(negedge clk);
        chk("wf_a5", dout_a_w[1], 32'hAABB0304);
        chk("rf_a5", dout_a_w[0], 32'hAABBCCDD);
        settle();
        acc(1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        @(negedge clk);
        chk("rd5_a", dout_a_w[0], 32'hAABB0304);
        chk("rd5_b", dout_b_w[1], 32'hAABB0304);
        settle();

        // Same-address write/write collisions.
        acc(1'b1, 1'b1, 4'hF, 4'd7, 32'h11111111, 1'b1, 1'b1, 4'b0011, 4'd7, 32'h22222222);
        @(negedge clk);
        chk("coll_hit", 32'(coll_w[0]), 32'd1);
        chk("wf_a7", dout_a_w[1], 32'h11111111);
        chk("wf_b7", dout_b_w[1], 32'hDEAD2222);
        settle();
        acc(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        @(negedge clk);
        chk("coll_store", dout_a_w[0], 32'h11112222);
        settle();
        acc(1'b1, 1'b1, 4'hF, 4'd7, 32'h33333333, 1'b1, 1'b1, 4'h0, 4'd7, 32'h44444444);
        @(negedge clk);
        chk("coll_none", 32'(coll_w[0]), 32'd0);
        chk("wf_b7_nostrb", dout_b_w[1], 32'h11112222);
        settle();
        acc(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        @(negedge clk);
        chk("nocoll_store", dout_a_w[0], 32'h33333333);
        settle();

        // Latency-2 back-to-back reads.
        acc(1'b1, 1'b1, 4'hF, 4'd0, 32'h100, 1'b1, 1'b1, 4'hF, 4'd1, 32'h101);
        acc(1'b1, 1'b1, 4'hF, 4'd2, 32'h102, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
        settle(); settle();
        fork
            begin
                acc(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
                acc(1'b1, 1'b0, 4'h0, 4'd1, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
                acc(1'b1, 1'b0, 4'h0, 4'd2, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    rvlog[i] = rv_a_w[2];
                    dlog[i] = dout_a_w[2];
                end
            end
        join
        chk("l2_rv0", 32'(rvlog[1]), 32'd0);
        chk("l2_rv1", 32'(rvlog[2]), 32'd1);
        chk("l2_rv2", 32'(rvlog[3]), 32'd1);
        chk("l2_rv3", 32'(rvlog[4]), 32'd1);
        chk("l2_d0", dlog[2], 32'h100);
        chk("l2_d1", dlog[3], 32'h101);
        chk("l2_d2", dlog[4], 32'h102);
        settle();

        // clear_req mid-operation, then reset at sweep cycle 6.
        en_a = 1'b1; we_a = 1'b0; aa = 4'd0; clear_req = 1'b1;
        settle();
        idle();
        settle(); settle();
        en_a = 1'b1; we_a = 1'b1; sa = 4'hF; aa = 4'd1; da = 32'h12345678;
        settle();
        idle();
        settle(); settle(); settle();
        rst = 1'b1;
        settle();
        rst = 1'b0;
        count_busy("busy_len_restart");
        acc(1'b1, 1'b0, 4'h0, 4'd1, 32'h0, 1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
        @(negedge clk);
        chk("sweep_a1", dout_a_w[0], INIT);
        chk("sweep_b2", dout_b_w[0], INIT);
        settle(); settle(); settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule

// File: doc/mem_tdp_pipe.md
Name: mem_tdp_pipe

Overview:
- Parametrised true dual-port block RAM. Successor to the bootloader's plain dual-port memory.
- Adds:
  - byte write strobes on both ports;
  - per-port read-during-write mode;
  - selectable read latency (1 or 2) with a read-valid strobe;
  - same-address/byte write-collision flag;
  - built-in clear engine that fills the array with INIT_VALUE after reset or on request.
- Sits between the bootloader/CPU instruction-data paths and on-chip storage.

Parameters:
- ADDR_WIDTH, 10, word address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width. Must be a multiple of 8. NB = DATA_WIDTH/8.
- READ_LATENCY, 1, cycles from accepted request to dout/rvalid. Legal values are 1 or 2; 2 adds an output register.
- RDW_MODE_A, 0, port A same-port read-during-write: 0 = read-first (old word), 1 = write-first (merged word).
- RDW_MODE_B, 0, as RDW_MODE_A for port B.
- CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset release.
- INIT_VALUE, 0, DATA_WIDTH-bit fill value for the clear sweep.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- clear_req  in  1  start clear sweep (pulse)
- init_busy  out  1  clear sweep in progress; port requests ignored while high
- en_a  in  1  port A access request
- we_a  in  1  port A write
- wstrb_a  in  NB  port A byte enables
- addr_a  in  ADDR_WIDTH  port A word address
- din_a  in  DATA_WIDTH  port A write data
- dout_a  out  DATA_WIDTH  port A read data
- rvalid_a  out  1  dout_a valid (one-cycle pulse)
- en_b, we_b, wstrb_b, addr_b, din_b, dout_b, rvalid_b: same as port A, for port B
- collision  out  1  same-cycle write/write overlap on any byte (pulse)

Behaviour:
- Reset (asynchronous, any time):
  - dout_a/b = 0, rvalid_a/b = 0, collision = 0.
  - Pipeline registers cleared; in-flight reads squashed.
  - FSM state and init_busy:
    - CLEAR_ON_RESET = 1: FSM -> CLEAR, clear address = 0, init_busy = 1.
    - CLEAR_ON_RESET = 0: FSM -> IDLE, init_busy = 0, array contents undefined.
  - Array contents are never touched by rst itself.
- FSM states:
  - IDLE:
    - clear_req = 1 -> CLEAR at the next edge; clear address = 0, init_busy = 1.
  - CLEAR:
    - Each cycle, write INIT_VALUE (all bytes) to the clear address, then increment it.
    - After writing address 2**ADDR_WIDTH-1 -> IDLE; init_busy = 0 in the following cycle.
    - Sweep length = 2**ADDR_WIDTH cycles.
    - clear_req is ignored while in CLEAR. Reset during CLEAR restarts the sweep from 0.
- Accepting requests:
  - A port request is accepted at edge T when en_x = 1 and init_busy = 0. Requests are ignored during CLEAR: no write, no rvalid.
  - Every accepted access, read or write, performs a read.
  - rvalid_x = 1 for exactly the cycle after edge T+READ_LATENCY-1, i.e. dout_x is valid in cycle T+READ_LATENCY.
  - dout_x holds its value when there is no new access.
- Writes:
  - Accepted access with we_x = 1 updates only bytes whose wstrb_x bit = 1.
  - wstrb = 0 with we = 1 acts as a pure read.
- Same-port read data:
  - read-first: word before the write.
  - write-first: old bytes where strobe = 0, din bytes where strobe = 1.
- Cross-port: a read on one port of an address written in the same cycle by the other port always returns the old word.
- Write/write to the same address in the same cycle:
  - Port B wins on overlapping bytes.
  - Non-overlapping bytes from both ports are written.
  - collision = 1 for one cycle at T+1 iff both writes accepted, addr_a == addr_b, and (wstrb_a & wstrb_b) != 0.
  - Write-first dout on each port reflects that port's own merged word, not the final stored word.
- READ_LATENCY = 2: the second stage is a plain register. Back-to-back accesses every cycle give back-to-back rvalid with no bubbles.

Test Plan:
- ADDR_WIDTH = 4, INIT_VALUE = 32'hDEADBEEF, release rst -> init_busy high for exactly 16 cycles. Then reads of addresses 0..15 on both ports return DEADBEEF, rvalid 1 cycle later.
- A writes addr 3, din 11223344, wstrb 4'b0101 over word 0 -> A reads 00220044. B reading addr 3 in the same cycle as the write returns 00000000.
- RDW_MODE_A = 1 vs 0: A writes addr 5 (old AABBCCDD, din 01020304, wstrb 4'b0011).
  - Mode 1: dout_a = AABB0304.
  - Mode 0: dout_a = AABBCCDD.
  - Either mode: a later read returns AABB0304.
- Same-cycle writes to addr 7: A din 11111111 wstrb 1111, B din 22222222 wstrb 0011 -> collision pulse at T+1; stored word 11112222. Repeat with B wstrb 0000 -> no collision.
- READ_LATENCY = 2: reads of addresses 0, 1, 2 on consecutive cycles -> rvalid high for 3 consecutive cycles starting at T+2, data in address order.
- clear_req mid-operation, then rst asserted at sweep cycle 6 -> sweep restarts from 0 and takes the full 16 cycles. en_a pulses during the sweep produce no rvalid and no write.
